mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   Memory-access stage of the 5-stage RV32 pipeline: consumes the EX/MEM bundle, performs word
//   load/store on a local data memory, resolves branch/jump redirect for IF, and registers the
//   MEM/WB bundle consumed by writeback. Sits directly downstream of the EX stage.
// PARAMETERS
//   DMEM_WORDS   1024   data memory depth in 32-bit words (power of 2)
//   DMEM_AW      10     word-address width, = log2(DMEM_WORDS)
// PORTS
//   clk               in   1   pipeline clock, rising edge
//   reset             in   1   asynchronous, active-high
//   valid_m           in   1   EX/MEM slot holds a real instruction (0 = bubble)
//   regwrite_m        in   1   instruction writes rd
//   result_src_m      in   2   writeback select: 00 ALU, 01 load data, 10 pc+4
//   memwrite_m        in   1   store
//   jump_m            in   1   unconditional jump
//   branch_m          in   1   conditional branch (taken when zero_flag_m=1)
//   zero_flag_m       in   1   ALU zero flag
//   pc_target_m       in   32  branch/jump target
//   alu_result_m      in   32  ALU result / effective byte address
//   writedata_m       in   32  store data (rs2)
//   pc_plus_4_m       in   32  link value
//   rd_m              in   5   destination register
//   pc_src            out  1   redirect IF to pc_branch_dest (combinational)
//   pc_branch_dest    out  32  = pc_target_m (combinational)
//   mem_wb_valid      out  1   registered valid_m
//   mem_wb_regwrite   out  1   registered, gated (see BEHAVIOUR)
//   mem_wb_result_src out  2   registered result_src_m
//   mem_wb_alu_result out  32  registered alu_result_m
//   mem_wb_read_data  out  32  load data, registered
//   mem_wb_pc_plus_4  out  32  registered pc_plus_4_m
//   mem_wb_rd         out  5   registered rd_m
//   misalign_err      out  1   sticky: misaligned load/store seen since reset
//   load_count        out  32  loads retired, saturating
//   store_count       out  32  stores performed, saturating
// BEHAVIOUR
//   - Reset (async, any time incl. mid-access): all mem_wb_* outputs, misalign_err and counters
//     go to 0 immediately; an in-flight store on the reset edge is NOT performed. DMEM contents
//     are not reset.
//   - pc_src = valid_m & (jump_m | (branch_m & zero_flag_m)); pc_branch_dest = pc_target_m.
//   - Word index = alu_result_m[DMEM_AW+1:2]; upper address bits ignored (address wraps).
//   - is_load = valid_m & (result_src_m==01); is_store = valid_m & memwrite_m;
//     aligned = (alu_result_m[1:0]==0).
//   - Store: if is_store & aligned, DMEM[idx] <= writedata_m on rising edge; visible to a load
//     in the next cycle. Misaligned store: suppressed, misalign_err <= 1.
//   - Load: synchronous read, latency 1: mem_wb_read_data <= DMEM[idx] on the same edge that
//     captures the rest of MEM/WB. Misaligned load: mem_wb_read_data <= 0, misalign_err <= 1,
//     mem_wb_regwrite <= 0 (no architectural write). Non-load: mem_wb_read_data <= 0.
//   - A store and a load are never in the same slot; if result_src_m==01 & memwrite_m both set,
//     the store takes effect and mem_wb_regwrite <= 0.
//   - Bubble (valid_m=0): no DMEM write, no counter change, mem_wb_regwrite <= 0, pc_src = 0;
//     other MEM/WB fields still register their inputs.
//   - MEM/WB register updates every cycle (no stall input); total latency EX/MEM -> MEM/WB = 1.
//   - load_count/store_count increment by 1 per aligned load/store; hold at 32'hFFFF_FFFF.
//   - misalign_err clears only on reset.
// STRUCTURE
//   - Shared package riscv_pkg: RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10; XLEN=32.
//   - One sub-module: data_mem (single-port sync-write/sync-read array, params DMEM_WORDS/DMEM_AW,
//     ports clk, we, addr, wdata, rdata). Control gating, redirect, counters and MEM/WB register
//     live in mem_stage.
// TESTING
//   1. Store 32'hDEADBEEF @0x40, next cycle load @0x40 -> mem_wb_read_data=DEADBEEF one cycle
//      later, mem_wb_regwrite=1, store_count=1, load_count=1.
//   2. Store @0x1002 (misaligned) then load @0x1000 -> old contents unchanged, misalign_err=1 and
//      stays 1; load @0x1001 -> read_data=0, regwrite=0.
//   3. branch_m=1, zero_flag_m=1, pc_target_m=0x80, valid_m=1 -> pc_src=1, pc_branch_dest=0x80
//      same cycle; zero_flag_m=0 -> pc_src=0; jump_m=1 with valid_m=0 -> pc_src=0.
//   4. Store @0x0 then store @(DMEM_WORDS*4) data 0x5 -> load @0x0 returns 0x5 (wrap).
//   5. Assert reset asynchronously between edges during a store -> all outputs 0 before next
//      edge, memory word at that address unchanged.
//   6. Force load_count to 32'hFFFF_FFFE via 2 loads from preset state (bench backdoor) -> after
//      3 loads, count holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 pipeline definitions: data width, writeback
//               select encodings and a saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN = 32;

    // Writeback source select carried down the pipeline
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [XLEN-1:0] CNT_MAX = {XLEN{1'b1}};

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem.sv
// ============================================================================
// Module      : data_mem
// Description : Single-port data memory, synchronous write and synchronous
//               read (read returns the contents before a same-edge write).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem #(
    parameter int DMEM_WORDS = 1024,
    parameter int DMEM_AW    = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DMEM_AW-1:0] addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [31:0] mem_q [0:DMEM_WORDS-1];

    // Array write and registered read; contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : RV32 memory-access stage. Word load/store on local DMEM,
//               branch/jump redirect, MEM/WB pipeline register, sticky
//               misalignment flag and saturating load/store counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import riscv_pkg::*;
#(
    parameter int DMEM_WORDS = 1024,
    parameter int DMEM_AW    = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_m,
    input  logic            regwrite_m,
    input  logic [1:0]      result_src_m,
    input  logic            memwrite_m,
    input  logic            jump_m,
    input  logic            branch_m,
    input  logic            zero_flag_m,
    input  logic [XLEN-1:0] pc_target_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] writedata_m,
    input  logic [XLEN-1:0] pc_plus_4_m,
    input  logic [4:0]      rd_m,
    output logic            pc_src,
    output logic [XLEN-1:0] pc_branch_dest,
    output logic            mem_wb_valid,
    output logic            mem_wb_regwrite,
    output logic [1:0]      mem_wb_result_src,
    output logic [XLEN-1:0] mem_wb_alu_result,
    output logic [XLEN-1:0] mem_wb_read_data,
    output logic [XLEN-1:0] mem_wb_pc_plus_4,
    output logic [4:0]      mem_wb_rd,
    output logic            misalign_err,
    output logic [XLEN-1:0] load_count,
    output logic [XLEN-1:0] store_count
);

    logic               ld_sel;
    logic               is_load;
    logic               is_store;
    logic               aligned;
    logic               mem_we;
    logic [DMEM_AW-1:0] word_idx;
    logic [XLEN-1:0]    dmem_rdata;
    logic               unused_addr_hi;

    logic               regwrite_d;
    logic               rd_en_d;
    logic               misalign_d;
    logic [XLEN-1:0]    load_count_d;
    logic [XLEN-1:0]    store_count_d;

    logic               valid_q;
    logic               regwrite_q;
    logic [1:0]         result_src_q;
    logic [XLEN-1:0]    alu_result_q;
    logic [XLEN-1:0]    pc_plus_4_q;
    logic [4:0]         rd_q;
    logic               rd_en_q;
    logic               misalign_q;
    logic [XLEN-1:0]    load_count_q;
    logic [XLEN-1:0]    store_count_q;

    // Redirect is purely combinational so IF can act in the same cycle
    assign pc_src         = valid_m & (jump_m | (branch_m & zero_flag_m));
    assign pc_branch_dest = pc_target_m;

    // Address bits above the word index are ignored, so addresses wrap
    assign word_idx       = alu_result_m[DMEM_AW+1:2];
    assign unused_addr_hi = ^alu_result_m[XLEN-1:DMEM_AW+2];
    assign aligned        = (alu_result_m[1:0] == 2'b00);

    // A slot flagged as both load and store behaves as a store
    assign ld_sel   = (result_src_m == RESULT_MEM);
    assign is_store = valid_m & memwrite_m;
    assign is_load  = valid_m & ld_sel & ~memwrite_m;

    // Gating with reset drops a store that coincides with a reset edge
    assign mem_we   = is_store & aligned & ~reset;

    data_mem #(
        .DMEM_WORDS (DMEM_WORDS),
        .DMEM_AW    (DMEM_AW)
    ) u_data_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_idx),
        .wdata (writedata_m),
        .rdata (dmem_rdata)
    );

    // Next-state for writeback gating, read qualifier, error flag and counters
    always_comb begin
        regwrite_d    = valid_m & regwrite_m & ~(ld_sel & (memwrite_m | ~aligned));
        rd_en_d       = is_load & aligned;
        misalign_d    = misalign_q | ((is_load | is_store) & ~aligned);
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
        if (is_load & aligned) begin
            load_count_d = sat_inc(load_count_q);
        end
        if (is_store & aligned) begin
            store_count_d = sat_inc(store_count_q);
        end
    end

    // MEM/WB pipeline register plus status state, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= 1'b0;
            regwrite_q    <= 1'b0;
            result_src_q  <= 2'b00;
            alu_result_q  <= '0;
            pc_plus_4_q   <= '0;
            rd_q          <= '0;
            rd_en_q       <= 1'b0;
            misalign_q    <= 1'b0;
            load_count_q  <= '0;
            store_count_q <= '0;
        end else begin
            valid_q       <= valid_m;
            regwrite_q    <= regwrite_d;
            result_src_q  <= result_src_m;
            alu_result_q  <= alu_result_m;
            pc_plus_4_q   <= pc_plus_4_m;
            rd_q          <= rd_m;
            rd_en_q       <= rd_en_d;
            misalign_q    <= misalign_d;
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
        end
    end

    // The memory read register has no reset, so its data is qualified by a
    // reset-cleared flag; non-loads and misaligned loads therefore show zero
    assign mem_wb_read_data  = rd_en_q ? dmem_rdata : '0;

    assign mem_wb_valid      = valid_q;
    assign mem_wb_regwrite   = regwrite_q;
    assign mem_wb_result_src = result_src_q;
    assign mem_wb_alu_result = alu_result_q;
    assign mem_wb_pc_plus_4  = pc_plus_4_q;
    assign mem_wb_rd         = rd_q;
    assign misalign_err      = misalign_q;
    assign load_count        = load_count_q;
    assign store_count       = store_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard testbench for mem_stage with a word-array
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    localparam int DMEM_WORDS = 1024;
    localparam int DMEM_AW    = 10;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic        j;
        logic        b;
        logic        z;
        logic [31:0] tgt;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
    } op_t;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
    } wb_t;

    typedef struct packed {
        logic        mis;
        logic [31:0] lc;
        logic [31:0] sc;
    } st_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m, regwrite_m, memwrite_m, jump_m, branch_m, zero_flag_m;
    logic [1:0]  result_src_m;
    logic [31:0] pc_target_m, alu_result_m, writedata_m, pc_plus_4_m;
    logic [4:0]  rd_m;
    logic        pc_src;
    logic [31:0] pc_branch_dest;
    logic        mem_wb_valid, mem_wb_regwrite, misalign_err;
    logic [1:0]  mem_wb_result_src;
    logic [31:0] mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4;
    logic [31:0] load_count, store_count;
    logic [4:0]  mem_wb_rd;

    int checks   = 0;
    int failures = 0;
    bit active   = 1'b0;

    wb_t qwb[$];
    st_t qst[$];

    // Reference model: plain word array and architectural status
    logic [31:0] mmem [0:DMEM_WORDS-1];
    logic        m_mis;
    logic [31:0] m_lc, m_sc;

    always #5 clk = ~clk;

    mem_stage #(
        .DMEM_WORDS (DMEM_WORDS),
        .DMEM_AW    (DMEM_AW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .valid_m           (valid_m),
        .regwrite_m        (regwrite_m),
        .result_src_m      (result_src_m),
        .memwrite_m        (memwrite_m),
        .jump_m            (jump_m),
        .branch_m          (branch_m),
        .zero_flag_m       (zero_flag_m),
        .pc_target_m       (pc_target_m),
        .alu_result_m      (alu_result_m),
        .writedata_m       (writedata_m),
        .pc_plus_4_m       (pc_plus_4_m),
        .rd_m              (rd_m),
        .pc_src            (pc_src),
        .pc_branch_dest    (pc_branch_dest),
        .mem_wb_valid      (mem_wb_valid),
        .mem_wb_regwrite   (mem_wb_regwrite),
        .mem_wb_result_src (mem_wb_result_src),
        .mem_wb_alu_result (mem_wb_alu_result),
        .mem_wb_read_data  (mem_wb_read_data),
        .mem_wb_pc_plus_4  (mem_wb_pc_plus_4),
        .mem_wb_rd         (mem_wb_rd),
        .misalign_err      (misalign_err),
        .load_count        (load_count),
        .store_count       (store_count)
    );

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk_bubble();
        op_t o;
        o = '0;
        return o;
    endfunction

    function automatic op_t mk_store(input logic [31:0] addr, input logic [31:0] data);
        op_t o;
        o     = '0;
        o.v   = 1'b1;
        o.mw  = 1'b1;
        o.alu = addr;
        o.wd  = data;
        o.pc4 = 32'($urandom());
        return o;
    endfunction

    function automatic op_t mk_load(input logic [31:0] addr, input logic [4:0] rd);
        op_t o;
        o     = '0;
        o.v   = 1'b1;
        o.rw  = 1'b1;
        o.rs  = 2'b01;
        o.alu = addr;
        o.rd  = rd;
        o.pc4 = 32'($urandom());
        return o;
    endfunction

    // Drive one EX/MEM slot, check redirect, predict the MEM/WB result
    task automatic step(input op_t o);
        wb_t  e;
        st_t  s;
        logic ld, st, al, exp_pc;
        int   idx;
        valid_m      = o.v;   regwrite_m  = o.rw;  result_src_m = o.rs;
        memwrite_m   = o.mw;  jump_m      = o.j;   branch_m     = o.b;
        zero_flag_m  = o.z;   pc_target_m = o.tgt; alu_result_m = o.alu;
        writedata_m  = o.wd;  pc_plus_4_m = o.pc4; rd_m         = o.rd;
        active = 1'b1;

        exp_pc = o.v && (o.j || (o.b && o.z));
        idx    = int'(o.alu / 4) % DMEM_WORDS;
        al     = (o.alu % 4) == 0;
        st     = o.v && o.mw;
        ld     = o.v && (o.rs == 2'b01) && !o.mw;

        e.v     = o.v;
        e.rs    = o.rs;
        e.alu   = o.alu;
        e.pc4   = o.pc4;
        e.rd    = o.rd;
        e.rdata = (ld && al) ? mmem[idx] : 32'h0;
        e.rw    = o.v && o.rw && !(ld && !al) && !(o.v && o.rs == 2'b01 && o.mw);
        if ((ld || st) && !al) m_mis = 1'b1;
        if (ld && al && m_lc != 32'hFFFF_FFFF) m_lc = m_lc + 1;
        if (st && al && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        if (st && al) mmem[idx] = o.wd;
        s.mis = m_mis;
        s.lc  = m_lc;
        s.sc  = m_sc;
        qwb.push_back(e);
        qst.push_back(s);

        #1;
        chk("pc_src", {159'b0, pc_src}, {159'b0, exp_pc});
        chk("pc_dest", {160'b0, pc_branch_dest}, {160'b0, o.tgt});
        @(negedge clk);
    endtask

    // Monitor: every non-reset clock edge while traffic is active retires one slot
    initial begin
        wb_t e;
        st_t s;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && active) begin
                if (qwb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard: got output with empty queue at %0t", $time);
                end else begin
                    e = qwb.pop_front();
                    s = qst.pop_front();
                    chk("mem_wb",
                        {87'b0, mem_wb_valid, mem_wb_regwrite, mem_wb_result_src, mem_wb_alu_result,
                         mem_wb_read_data, mem_wb_pc_plus_4, mem_wb_rd},
                        {87'b0, e});
                    chk("status", {127'b0, misalign_err, load_count, store_count}, {127'b0, s});
                end
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk(name, {22'b0, mem_wb_valid, mem_wb_regwrite, mem_wb_result_src, mem_wb_alu_result,
                   mem_wb_read_data, mem_wb_pc_plus_4, mem_wb_rd, misalign_err, load_count,
                   store_count}, 192'b0);
    endtask

    initial begin
        op_t o;
        int  kind;

        m_mis = 1'b0;
        m_lc  = '0;
        m_sc  = '0;
        for (int i = 0; i < DMEM_WORDS; i++) mmem[i] = '0;

        reset = 1'b1;
        o = mk_bubble();
        valid_m = 0; regwrite_m = 0; result_src_m = 0; memwrite_m = 0; jump_m = 0;
        branch_m = 0; zero_flag_m = 0; pc_target_m = 0; alu_result_m = 0;
        writedata_m = 0; pc_plus_4_m = 0; rd_m = 0;
        #3;
        chk_all_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Store then load back the same word, counters move from zero
        step(mk_store(32'h40, 32'hDEAD_BEEF));
        step(mk_load(32'h40, 5'd7));
        step(mk_bubble());
        chk("cnt_after_first", {128'b0, load_count, store_count}, {128'b0, 32'd1, 32'd1});

        // Fill every word so later loads have defined contents
        for (int i = 0; i < DMEM_WORDS; i++) step(mk_store(32'(i * 4), 32'($urandom())));

        // Misaligned store is dropped, aligned load sees old data, misaligned load yields 0
        step(mk_store(32'h1002, 32'h1111_2222));
        step(mk_load(32'h1000, 5'd3));
        step(mk_load(32'h1001, 5'd4));
        step(mk_bubble());
        chk("misalign_sticky", {191'b0, misalign_err}, {191'b0, 1'b1});

        // Redirect cases
        o = mk_bubble(); o.v = 1; o.b = 1; o.z = 1; o.tgt = 32'h80; step(o);
        o.z = 0; step(o);
        o = mk_bubble(); o.j = 1; o.tgt = 32'h84; step(o);
        o.v = 1; step(o);

        // Upper address bits wrap onto the same word
        step(mk_store(32'h0, 32'hCAFE_0001));
        step(mk_store(32'(DMEM_WORDS * 4), 32'h5));
        step(mk_load(32'h0, 5'd9));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            kind  = $urandom_range(0, 9);
            o.v   = 1'b1;
            o.rw  = 1'($urandom());
            o.rs  = 2'($urandom());
            o.mw  = 1'b0;
            o.j   = ($urandom_range(0, 7) == 0);
            o.b   = 1'($urandom());
            o.z   = 1'($urandom());
            o.tgt = 32'($urandom());
            o.alu = 32'($urandom()) & 32'hFFFF_FFFC;
            o.wd  = 32'($urandom());
            o.pc4 = 32'($urandom());
            o.rd  = 5'($urandom());
            if (kind <= 3) begin
                o.rs = 2'b01;
            end else if (kind <= 6) begin
                o.mw = 1'b1;
                o.rs = 2'b00;
            end else if (kind == 7) begin
                o.mw = 1'($urandom());
            end else if (kind == 8) begin
                o.v  = 1'b0;
                o.mw = 1'($urandom());
            end else begin
                o.alu = 32'($urandom());
                o.mw  = 1'($urandom());
            end
            step(o);
        end

        // Asynchronous reset mid-store: outputs clear at once, store dropped
        active = 1'b0;
        valid_m = 1; memwrite_m = 1; regwrite_m = 0; result_src_m = 0;
        jump_m = 0; branch_m = 0; alu_result_m = 32'h80; writedata_m = 32'h1234_5678;
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        chk_all_zero("reset_held");
        @(negedge clk);
        reset = 1'b0;
        qwb.delete();
        qst.delete();
        m_mis = 1'b0;
        m_lc  = '0;
        m_sc  = '0;
        step(mk_load(32'h80, 5'd1));

        // Saturation: preset near the top, then keep loading
        force dut.load_count_q = 32'hFFFF_FFFC;
        #1;
        release dut.load_count_q;
        m_lc = 32'hFFFF_FFFC;
        for (int i = 0; i < 5; i++) step(mk_load(32'(i * 4), 5'd2));
        active = 1'b0;
        chk("load_sat", {160'b0, load_count}, {160'b0, 32'hFFFF_FFFF});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
